voice_scheduler: RTL and testbench

//   Allocates incoming note requests to the three synth voices (a/b/c) feeding

---
 rtl/voice_scheduler.sv | 139 +++++++++++++
 tb/tb_voice_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Three-voice note allocator: lowest-idle allocation, optional round-robin
// stealing, per-voice tick-driven duration and stored stereo routing code.
module voice_scheduler #(
   parameter int unsigned PITCH_W = 8,
   parameter int unsigned DUR_W   = 16,
   parameter int unsigned STEAL   = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   tick_in,
   input  logic                   req_valid_in,
   output logic                   req_ready_out,
   input  logic [PITCH_W-1:0]     req_pitch_in,
   input  logic [DUR_W-1:0]       req_dur_in,
   input  logic [1:0]             req_pan_in,
   input  logic                   stereo_mode_in,
   output logic [2:0]             voice_active_out,
   output logic [3*PITCH_W-1:0]   voice_pitch_out,
   output logic [1:0]             stereo_data_a_out,
   output logic [1:0]             stereo_data_b_out,
   output logic [1:0]             stereo_data_c_out,
   output logic                   stereo_on_out,
   output logic                   steal_out
);

   localparam logic [0:0] V_IDLE   = 1'b0;
   localparam logic [0:0] V_ACTIVE = 1'b1;
   localparam logic [1:0] PAN_L    = 2'b10;
   localparam logic [1:0] PAN_R    = 2'b01;
   localparam logic [1:0] PAN_B    = 2'b11;
   localparam logic       STEAL_EN = (STEAL != 0);

   logic [2:0]         state_q, state_d;
   logic [DUR_W-1:0]   cnt_q[3], cnt_d[3];
   logic [PITCH_W-1:0] pitch_q[3], pitch_d[3];
   logic [1:0]         pan_q[3], pan_d[3];
   logic [1:0]         auto_q, auto_d;
   logic [1:0]         steal_ptr_q, steal_ptr_d;
   logic               steal_q, steal_d;
   logic               stereo_q, stereo_d;

   logic               alloc_hit_c;
   logic [1:0]         alloc_idx_c;
   logic               accept_c;
   logic               load_c;
   logic [1:0]         pan_eff_c;

   // Ready whenever a voice is free or stealing is allowed; held low in reset.
   assign req_ready_out = ~rst_in & ((state_q != 3'b111) | STEAL_EN);
   assign accept_c      = req_valid_in & req_ready_out;
   assign load_c        = accept_c & (req_dur_in != '0);
   assign pan_eff_c     = (req_pan_in == 2'b00) ? auto_q : req_pan_in;

   // Lowest-index idle voice from registered state; otherwise the steal pointer.
   always_comb begin
      alloc_hit_c = 1'b0;
      alloc_idx_c = steal_ptr_q;
      for (int i = 2; i >= 0; i--) begin
         if (state_q[i] == V_IDLE) begin
            alloc_hit_c = 1'b1;
            alloc_idx_c = 2'(i);
         end
      end
   end

   // Next state: tick decrement/retire first, then a load overrides its voice.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pitch_d     = pitch_q;
      pan_d       = pan_q;
      auto_d      = auto_q;
      steal_ptr_d = steal_ptr_q;
      steal_d     = 1'b0;
      stereo_d    = stereo_mode_in;
      for (int i = 0; i < 3; i++) begin
         if (tick_in && (state_q[i] == V_ACTIVE)) begin
            cnt_d[i] = cnt_q[i] - DUR_W'(1);
            if (cnt_q[i] == DUR_W'(1)) begin
               state_d[i] = V_IDLE;
               pan_d[i]   = 2'b00;
            end
         end
      end
      if (load_c) begin
         state_d[alloc_idx_c] = V_ACTIVE;
         cnt_d[alloc_idx_c]   = req_dur_in;
         pitch_d[alloc_idx_c] = req_pitch_in;
         pan_d[alloc_idx_c]   = pan_eff_c;
         if (req_pan_in == 2'b00) begin
            case (auto_q)
               PAN_L:   auto_d = PAN_R;
               PAN_R:   auto_d = PAN_B;
               default: auto_d = PAN_L;
            endcase
         end
         if (!alloc_hit_c) begin
            steal_d     = 1'b1;
            steal_ptr_d = (steal_ptr_q == 2'd2) ? 2'd0 : steal_ptr_q + 2'd1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= '0;
         auto_q      <= PAN_L;
         steal_ptr_q <= 2'd0;
         steal_q     <= 1'b0;
         stereo_q    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i]   <= '0;
            pitch_q[i] <= '0;
            pan_q[i]   <= 2'b00;
         end
      end else begin
         state_q     <= state_d;
         auto_q      <= auto_d;
         steal_ptr_q <= steal_ptr_d;
         steal_q     <= steal_d;
         stereo_q    <= stereo_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i]   <= cnt_d[i];
            pitch_q[i] <= pitch_d[i];
            pan_q[i]   <= pan_d[i];
         end
      end
   end

   assign voice_active_out  = state_q;
   assign voice_pitch_out   = {pitch_q[2], pitch_q[1], pitch_q[0]};
   assign stereo_data_a_out = pan_q[0];
   assign stereo_data_b_out = pan_q[1];
   assign stereo_data_c_out = pan_q[2];
   assign stereo_on_out     = stereo_q;
   assign steal_out         = steal_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: one stealing and one backpressure instance.
module tb_voice_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic mode = 1'b0;

   logic        s_valid = 1'b0, s_ready;
   logic [7:0]  s_pitch = '0;
   logic [15:0] s_dur = '0;
   logic [1:0]  s_pan = '0;
   logic [2:0]  s_act;
   logic [23:0] s_pv;
   logic [1:0]  s_sa, s_sb, s_sc;
   logic        s_son, s_steal;

   logic        b_valid = 1'b0, b_ready;
   logic [7:0]  b_pitch = '0;
   logic [15:0] b_dur = '0;
   logic [1:0]  b_pan = '0;
   logic [2:0]  b_act;
   logic [23:0] b_pv;
   logic [1:0]  b_sa, b_sb, b_sc;
   logic        b_son, b_steal;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   voice_scheduler #(.PITCH_W(8), .DUR_W(16), .STEAL(1)) u_st (
      .clk_in(clk), .rst_in(rst), .tick_in(tick),
      .req_valid_in(s_valid), .req_ready_out(s_ready),
      .req_pitch_in(s_pitch), .req_dur_in(s_dur), .req_pan_in(s_pan),
      .stereo_mode_in(mode), .voice_active_out(s_act), .voice_pitch_out(s_pv),
      .stereo_data_a_out(s_sa), .stereo_data_b_out(s_sb), .stereo_data_c_out(s_sc),
      .stereo_on_out(s_son), .steal_out(s_steal));

   voice_scheduler #(.PITCH_W(8), .DUR_W(16), .STEAL(0)) u_bp (
      .clk_in(clk), .rst_in(rst), .tick_in(tick),
      .req_valid_in(b_valid), .req_ready_out(b_ready),
      .req_pitch_in(b_pitch), .req_dur_in(b_dur), .req_pan_in(b_pan),
      .stereo_mode_in(mode), .voice_active_out(b_act), .voice_pitch_out(b_pv),
      .stereo_data_a_out(b_sa), .stereo_data_b_out(b_sb), .stereo_data_c_out(b_sc),
      .stereo_on_out(b_son), .steal_out(b_steal));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req_s(input logic [7:0] p, input logic [15:0] d, input logic [1:0] pn);
      s_valid = 1'b1; s_pitch = p; s_dur = d; s_pan = pn;
      cyc();
      s_valid = 1'b0;
   endtask

   task automatic req_b(input logic [7:0] p, input logic [15:0] d, input logic [1:0] pn);
      b_valid = 1'b1; b_pitch = p; b_dur = d; b_pan = pn;
      cyc();
      b_valid = 1'b0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_ready_s", s_ready, 0);
      chk("rst_ready_b", b_ready, 0);
      chk("rst_active", s_act, 0);
      chk("rst_pitch", s_pv, 0);
      chk("rst_steal", s_steal, 0);
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("rel_ready_s", s_ready, 1);
      chk("rel_ready_b", b_ready, 1);

      // stereo_on follows mode with one cycle delay
      mode = 1'b1;
      chk("son_before", s_son, 0);
      cyc();
      chk("son_on", s_son, 1);
      mode = 1'b0;
      cyc();
      chk("son_off", s_son, 0);

      // Three auto-pan notes fill a, b, c
      req_s(8'd10, 16'd4, 2'b00);
      chk("t1_act_a", s_act, 3'b001);
      chk("t1_pan_a", s_sa, 2'b10);
      req_s(8'd20, 16'd4, 2'b00);
      chk("t1_act_b", s_act, 3'b011);
      chk("t1_pan_b", s_sb, 2'b01);
      req_s(8'd30, 16'd4, 2'b00);
      chk("t1_act_c", s_act, 3'b111);
      chk("t1_pan_c", s_sc, 2'b11);
      chk("t1_pitch", s_pv, 24'h1E140A);
      for (int k = 1; k <= 3; k++) begin
         pulse_tick();
         chk("t1_tick_busy", s_act, 3'b111);
      end
      pulse_tick();
      chk("t1_retired", s_act, 3'b000);
      chk("t1_pan_idle", {s_sa, s_sb, s_sc}, 6'b000000);
      chk("t1_pitch_hold", s_pv, 24'h1E140A);

      // Stealing: round-robin from voice a
      req_s(8'd1, 16'd5, 2'b01);
      req_s(8'd2, 16'd5, 2'b10);
      req_s(8'd3, 16'd5, 2'b11);
      chk("st_full", s_act, 3'b111);
      chk("st_ready", s_ready, 1);
      chk("st_no_steal", s_steal, 0);
      req_s(8'd40, 16'd5, 2'b01);
      chk("st1_pitch", s_pv, 24'h030228);
      chk("st1_pulse", s_steal, 1);
      chk("st1_pan", s_sa, 2'b01);
      chk("st1_act", s_act, 3'b111);
      cyc();
      chk("st1_pulse_end", s_steal, 0);
      req_s(8'd50, 16'd5, 2'b10);
      chk("st2_pitch", s_pv, 24'h033228);
      chk("st2_pulse", s_steal, 1);
      chk("st2_pan", s_sb, 2'b10);

      // Zero-duration auto request is dropped without advancing auto-pan
      do_reset();
      req_s(8'd77, 16'd0, 2'b00);
      chk("d0_act", s_act, 3'b000);
      chk("d0_steal", s_steal, 0);
      req_s(8'd5, 16'd3, 2'b00);
      chk("d0_next_act", s_act, 3'b001);
      chk("d0_next_pan", s_sa, 2'b10);
      req_s(8'd9, 16'd5, 2'b00);
      chk("d0_b_pan", s_sb, 2'b01);
      chk("mid_two", s_act, 3'b011);

      // Asynchronous reset with two voices sounding
      rst = 1'b1;
      #1;
      chk("mid_act", s_act, 3'b000);
      chk("mid_pans", {s_sa, s_sb, s_sc}, 6'b000000);
      chk("mid_ready", s_ready, 0);
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", s_ready, 1);
      req_s(8'd12, 16'd3, 2'b00);
      chk("mid_first_pan", s_sa, 2'b10);

      // Backpressure instance: request held while retiring a, lands next cycle
      do_reset();
      req_b(8'd1, 16'd2, 2'b01);
      req_b(8'd2, 16'd4, 2'b10);
      req_b(8'd3, 16'd6, 2'b11);
      chk("bp_full", b_act, 3'b111);
      chk("bp_not_ready", b_ready, 0);
      b_valid = 1'b1; b_pitch = 8'd9; b_dur = 16'd9; b_pan = 2'b01;
      tick = 1'b1;
      cyc();
      chk("bp_held_act", b_act, 3'b111);
      chk("bp_held_pitch", b_pv, 24'h030201);
      chk("bp_held_ready", b_ready, 0);
      cyc();
      tick = 1'b0;
      chk("bp_retire_a", b_act, 3'b110);
      chk("bp_retire_pitch", b_pv, 24'h030201);
      chk("bp_retire_pan", b_sa, 2'b00);
      chk("bp_ready_now", b_ready, 1);
      cyc();
      chk("bp_land_a_act", b_act, 3'b111);
      chk("bp_land_a_pitch", b_pv, 24'h030209);
      chk("bp_land_a_pan", b_sa, 2'b01);
      chk("bp_busy_again", b_ready, 0);

      // Held request waits for tick to free voice b
      b_pitch = 8'd11; b_dur = 16'd9; b_pan = 2'b10;
      tick = 1'b1;
      cyc();
      chk("bp_b_count", b_act, 3'b111);
      cyc();
      tick = 1'b0;
      chk("bp_free_b", b_act, 3'b101);
      chk("bp_free_b_ready", b_ready, 1);
      cyc();
      b_valid = 1'b0;
      chk("bp_land_b_act", b_act, 3'b111);
      chk("bp_land_b_pitch", b_pv, 24'h030B09);
      chk("bp_land_b_pan", b_sb, 2'b10);
      chk("bp_never_steal", b_steal, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
